serial_slave_bram_split: RTL and testbench

//  Serial-bus slave with an internal inferred block RAM, configurable read latency and optional split-transaction support.

---
 rtl/serial_slave_bram_split.sv | 166 ++++++++++++++++
 tb/tb_serial_slave_bram_split.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_bram_split.sv
// Serial-bus memory slave: shifts in address/write data LSB first, accesses an
// inferred block RAM behind a fixed-latency read pipeline, and shifts read data back out.
module serial_slave_bram_split #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 2,
  parameter int SPLIT_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic [DATA_WIDTH-1:0] demo_data
);

  localparam int AC_W = $clog2(ADDR_WIDTH + 1);
  localparam int DC_W = $clog2(DATA_WIDTH + 1);
  localparam int WC_W = $clog2(READ_LATENCY + 1);

  localparam logic [AC_W-1:0]       ADDR_LAST = AC_W'(ADDR_WIDTH - 1);
  localparam logic [DC_W-1:0]       DATA_LAST = DC_W'(DATA_WIDTH - 1);
  localparam logic [WC_W-1:0]       WAIT_LAST = WC_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RSPLIT, RDATA
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [DATA_WIDTH-1:0] rdata_sr;
  logic [AC_W-1:0]       addr_cnt;
  logic [DC_W-1:0]       data_cnt;
  logic [WC_W-1:0]       wait_cnt;
  logic                  mode;
  logic                  data_rdy;
  logic                  grant_seen;
  logic                  capture;
  logic                  addr_ok;
  logic                  do_write;

  logic [DATA_WIDTH-1:0] mem     [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rd_pipe [READ_LATENCY];

  assign addr_ok  = ({1'b0, addr_sr} < MEM_LIMIT);
  assign do_write = (state == WRITE) && addr_ok && !rst;

  // Stage 0 reads every cycle; out-of-range addresses are forced to zero so the
  // read keeps its normal timing.
  always_ff @(posedge clk) begin
    if (do_write)
      mem[addr_sr] <= data_sr;
    rd_pipe[0] <= addr_ok ? mem[addr_sr] : '0;
    for (int i = 1; i < READ_LATENCY; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    sready     = 1'b0;
    svalid     = 1'b0;
    srdata     = 1'b0;
    ssplit     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        sready = 1'b1;
        if (mvalid) next_state = ADDR;
      end
      ADDR:
        if (mvalid && addr_cnt == ADDR_LAST) next_state = mode ? WDATA : RREQ;
      WDATA:
        if (mvalid && data_cnt == DATA_LAST) next_state = WRITE;
      WRITE:
        next_state = IDLE;
      RREQ:
        next_state = (SPLIT_EN != 0) ? RSPLIT : RWAIT;
      RWAIT: begin
        capture = !data_rdy && (wait_cnt == WAIT_LAST);
        if (capture) next_state = RDATA;
      end
      RSPLIT: begin
        ssplit  = !grant_seen;
        capture = !data_rdy && (wait_cnt == WAIT_LAST);
        // A grant that arrived early is held in grant_seen and still counts here.
        if ((data_rdy || capture) && (grant_seen || split_grant)) next_state = RDATA;
      end
      RDATA: begin
        svalid = 1'b1;
        srdata = rdata_sr[0];
        if (data_cnt == DATA_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_sr    <= '0;
      data_sr    <= '0;
      rdata_sr   <= '0;
      addr_cnt   <= '0;
      data_cnt   <= '0;
      wait_cnt   <= '0;
      mode       <= 1'b0;
      data_rdy   <= 1'b0;
      grant_seen <= 1'b0;
      demo_data  <= '0;
    end else begin
      case (state)
        IDLE:
          if (mvalid) begin
            mode       <= smode;
            addr_sr    <= {swdata, addr_sr[ADDR_WIDTH-1:1]};
            addr_cnt   <= AC_W'(1);
            data_cnt   <= '0;
            wait_cnt   <= '0;
            data_rdy   <= 1'b0;
            grant_seen <= 1'b0;
          end
        ADDR:
          if (mvalid) begin
            addr_sr  <= {swdata, addr_sr[ADDR_WIDTH-1:1]};
            addr_cnt <= addr_cnt + 1'b1;
          end
        WDATA:
          if (mvalid) begin
            data_sr  <= {swdata, data_sr[DATA_WIDTH-1:1]};
            data_cnt <= data_cnt + 1'b1;
          end
        WRITE: begin
          if (addr_ok) demo_data <= data_sr;
          data_cnt <= '0;
        end
        RWAIT, RSPLIT: begin
          if (!data_rdy) wait_cnt <= wait_cnt + 1'b1;
          if (capture) begin
            rdata_sr <= rd_pipe[READ_LATENCY-1];
            data_rdy <= 1'b1;
          end
          if (state == RSPLIT && split_grant) grant_seen <= 1'b1;
        end
        RDATA: begin
          rdata_sr <= {1'b0, rdata_sr[DATA_WIDTH-1:1]};
          data_cnt <= data_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_bram_split.sv
// Directed bench: instance A (no split, latency 2, full memory) and instance B
// (split, latency 4, 3000 words) share the bus signals, gated by sel.
module tb_serial_slave_bram_split;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic swdata, smode, mvalid, split_grant;

  logic       a_mvalid, a_srdata, a_svalid, a_sready, a_ssplit;
  logic       b_mvalid, b_srdata, b_svalid, b_sready, b_ssplit;
  logic [7:0] a_demo, b_demo;
  logic       obs_srdata, obs_svalid, obs_sready, obs_ssplit;
  logic [7:0] obs_demo;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign a_mvalid   = mvalid & ~sel;
  assign b_mvalid   = mvalid & sel;
  assign obs_srdata = sel ? b_srdata : a_srdata;
  assign obs_svalid = sel ? b_svalid : a_svalid;
  assign obs_sready = sel ? b_sready : a_sready;
  assign obs_ssplit = sel ? b_ssplit : a_ssplit;
  assign obs_demo   = sel ? b_demo   : a_demo;

  serial_slave_bram_split #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_SIZE(4096), .READ_LATENCY(2), .SPLIT_EN(0)
  ) dut_a (
    .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(a_mvalid),
    .srdata(a_srdata), .svalid(a_svalid), .sready(a_sready), .ssplit(a_ssplit),
    .split_grant(1'b0), .demo_data(a_demo)
  );

  serial_slave_bram_split #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_SIZE(3000), .READ_LATENCY(4), .SPLIT_EN(1)
  ) dut_b (
    .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(b_mvalid),
    .srdata(b_srdata), .svalid(b_svalid), .sready(b_sready), .ssplit(b_ssplit),
    .split_grant(split_grant), .demo_data(b_demo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    else
      passed++;
  endtask

  // Drives nbits of {data, addr} LSB first; stall_at inserts three idle cycles
  // (with a garbage 1 on swdata) after that bit index.
  task automatic applyStimulus(input logic mode, input logic [11:0] addr, input logic [7:0] data,
                               input int nbits, input int stall_at);
    logic [19:0] bits;
    bits = {data, addr};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mvalid = 1'b1;
      smode  = mode;
      swdata = bits[i];
      if (i == stall_at) begin
        repeat (3) begin
          @(negedge clk);
          mvalid = 1'b0;
          swdata = 1'b1;
        end
      end
    end
    @(negedge clk);
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask

  task automatic writeAndCheck(input string tag, input logic [11:0] addr, input logic [7:0] data,
                               input int stall_at, input logic [7:0] exp_demo);
    applyStimulus(1'b1, addr, data, 20, stall_at);
    checkOutput({tag, "_sready_busy"}, 32'(obs_sready), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_sready_back"}, 32'(obs_sready), 32'd1);
    checkOutput({tag, "_demo"}, 32'(obs_demo), 32'(exp_demo));
  endtask

  // start is the current cycle offset from the last address bit.
  task automatic readTail(input string tag, input int start, input logic [7:0] exp_word, input int exp_off);
    int off;
    int first_off;
    int nvalid;
    logic [7:0] word;
    off = start;
    first_off = -1;
    nvalid = 0;
    word = '0;
    while (!obs_svalid && off < start + 100) begin
      @(negedge clk);
      off++;
    end
    if (obs_svalid) begin
      first_off = off;
      for (int i = 0; i < 8; i++) begin
        word[i] = obs_srdata;
        nvalid += int'(obs_svalid);
        @(negedge clk);
      end
    end
    checkOutput({tag, "_latency"}, 32'(first_off), 32'(exp_off));
    checkOutput({tag, "_word"}, 32'(word), 32'(exp_word));
    checkOutput({tag, "_nvalid"}, 32'(nvalid), 32'd8);
    checkOutput({tag, "_svalid_end"}, 32'(obs_svalid), 32'd0);
    checkOutput({tag, "_sready_end"}, 32'(obs_sready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0; split_grant = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_a_sready", 32'(obs_sready), 32'd1);
    checkOutput("rst_a_svalid", 32'(obs_svalid), 32'd0);
    checkOutput("rst_a_srdata", 32'(obs_srdata), 32'd0);
    checkOutput("rst_a_demo", 32'(obs_demo), 32'd0);
    sel = 1'b1;
    checkOutput("rst_b_ssplit", 32'(obs_ssplit), 32'd0);
    checkOutput("rst_b_sready", 32'(obs_sready), 32'd1);
    sel = 1'b0;

    // Basic write and read, no split, latency 2: first svalid at last addr bit + 4
    writeAndCheck("t1_wr", 12'h0A5, 8'hA5, -1, 8'hA5);
    applyStimulus(1'b0, 12'h0A5, 8'h00, 12, -1);
    readTail("t1_rd", 1, 8'hA5, 4);

    // Stalled write
    writeAndCheck("t2_wr", 12'h123, 8'h5A, 5, 8'h5A);
    applyStimulus(1'b0, 12'h123, 8'h00, 12, -1);
    readTail("t2_rd", 1, 8'h5A, 4);

    // Reset mid-WDATA with mvalid high during reset
    writeAndCheck("t5_wr", 12'h010, 8'h3C, -1, 8'h3C);
    applyStimulus(1'b1, 12'h010, 8'hC3, 16, -1);
    rst = 1'b1; mvalid = 1'b1; swdata = 1'b1;
    @(negedge clk);
    rst = 1'b0; mvalid = 1'b0; swdata = 1'b0;
    checkOutput("t5_sready", 32'(obs_sready), 32'd1);
    checkOutput("t5_svalid", 32'(obs_svalid), 32'd0);
    checkOutput("t5_ssplit", 32'(obs_ssplit), 32'd0);
    checkOutput("t5_demo", 32'(obs_demo), 32'd0);
    applyStimulus(1'b0, 12'h010, 8'h00, 12, -1);
    readTail("t5_rd", 1, 8'h3C, 4);

    // Split instance: grant held off for 20 cycles
    sel = 1'b1;
    writeAndCheck("t3_wr", 12'h100, 8'h77, -1, 8'h77);
    applyStimulus(1'b0, 12'h100, 8'h00, 12, -1);
    checkOutput("t3_ssplit_rreq", 32'(obs_ssplit), 32'd0);
    @(negedge clk);
    checkOutput("t3_ssplit_on", 32'(obs_ssplit), 32'd1);
    repeat (19) @(negedge clk);
    checkOutput("t3_ssplit_hold", 32'(obs_ssplit), 32'd1);
    checkOutput("t3_svalid_hold", 32'(obs_svalid), 32'd0);
    split_grant = 1'b1;
    @(negedge clk);
    split_grant = 1'b0;
    checkOutput("t3_ssplit_off", 32'(obs_ssplit), 32'd0);
    readTail("t3_rd", 1, 8'h77, 1);

    // Early one-cycle grant pulse is remembered
    writeAndCheck("t4_wr", 12'h200, 8'h96, -1, 8'h96);
    applyStimulus(1'b0, 12'h200, 8'h00, 12, -1);
    @(negedge clk);
    split_grant = 1'b1;
    @(negedge clk);
    split_grant = 1'b0;
    checkOutput("t4_ssplit_off", 32'(obs_ssplit), 32'd0);
    readTail("t4_rd", 3, 8'h96, 6);

    // Address beyond MEM_SIZE: write dropped, read returns zero with normal timing
    writeAndCheck("t6_wr", 12'hBC0, 8'hFF, -1, 8'h96);
    split_grant = 1'b1;
    applyStimulus(1'b0, 12'hBC0, 8'h00, 12, -1);
    readTail("t6_rd", 1, 8'h00, 6);
    split_grant = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
